// File: rtl/cnt_gate_sched.sv
// Round-robin scheduler that hands a shared gated counter to one requester per burst.
// Optional build macro CNT_GATE_SCHED_ABORT_EN: dropping the granted req during RUN ends the burst early.
module cnt_gate_sched #(
  parameter int NREQ = 4,
  parameter int LW   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   burst_len,
  output logic [NREQ-1:0] grant,
  output logic            cnt_en,
  output logic            cnt_clr,
  output logic            busy,
  output logic            done,
  output logic [LW:0]     remaining
);

  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // One extra bit so last+1+offset never wraps before the modulo step.
  localparam int IW = SW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t          state;
  logic [SW-1:0]   last;
  logic [SW-1:0]   gidx;
  logic [SW-1:0]   winner;
  logic [IW-1:0]   shamt;
  logic [IW-1:0]   pick_off;
  logic [IW-1:0]   sum;
  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0] rot;
  logic [NREQ-1:0] grant_next;
  logic            found;
  logic [LW:0]     len_ext;

  // Rotate requests so bit 0 of rot is the requester right after the last owner.
  assign req_dbl = {req, req};
  assign shamt   = IW'(last) + IW'(1);
  assign rot     = NREQ'(req_dbl >> shamt);

  always_comb begin
    found    = 1'b0;
    pick_off = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        found    = 1'b1;
        pick_off = IW'(k);
      end
    end
  end

  assign sum    = shamt + pick_off;
  assign winner = (sum >= IW'(NREQ)) ? SW'(sum - IW'(NREQ)) : SW'(sum);

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
      assign grant_next[gi] = (winner == SW'(gi));
    end
  endgenerate

  assign len_ext = (burst_len == '0) ? {1'b1, {LW{1'b0}}} : {1'b0, burst_len};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      grant     <= '0;
      cnt_en    <= 1'b0;
      cnt_clr   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
      last      <= SW'(NREQ - 1);
      gidx      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state     <= LOAD;
            grant     <= grant_next;
            gidx      <= winner;
            cnt_clr   <= 1'b1;
            busy      <= 1'b1;
            remaining <= len_ext;
          end
        end
        LOAD: begin
          state   <= RUN;
          cnt_clr <= 1'b0;
          cnt_en  <= 1'b1;
        end
        RUN: begin
`ifdef CNT_GATE_SCHED_ABORT_EN
          if (!(|(req & grant))) begin
            // Early end: remaining keeps the count that was still owed.
            state  <= DONE;
            cnt_en <= 1'b0;
            done   <= 1'b1;
          end else
`endif
          if (remaining == (LW+1)'(1)) begin
            state     <= DONE;
            cnt_en    <= 1'b0;
            done      <= 1'b1;
            remaining <= '0;
          end else begin
            remaining <= remaining - (LW+1)'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          grant <= '0;
          last  <= gidx;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
